// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared state encoding, default widths and counter sizing for the UART/ALU frame controller
package uart_alu_pkg;
  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX} state_e;
  localparam int DEF_BYTE_W = 8;
  localparam int DEF_OPCODE_W = 6;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_alu_frame_ctrl_frame_timer.sv
// frame_timer: saturating inter-byte idle counter; expired marks the idle cycle that reaches TIMEOUT_CYCLES
module frame_timer
  import uart_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int TW = cnt_w(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] cnt_q, cnt_d;
  // a clear in the same cycle always beats expiry
  always_comb begin
    cnt_d = (!enable || clear) ? '0 : (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
    expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (cnt_q >= TMAX - 1'b1);
  end
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl: pops A/B/opcode frames from the RX FIFO, drives the ALU, serialises results into the TX FIFO
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int OPERAND_BYTES = 2,
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_W-1:0]                 i_rx_data,
  input  logic                              i_rx_empty,
  output logic                              o_rx_rd,
  input  logic                              i_tx_full,
  output logic                              o_tx_wr,
  output logic [BYTE_W-1:0]                 o_tx_data,
  output logic [BYTE_W*OPERAND_BYTES-1:0]   o_op_a,
  output logic [BYTE_W*OPERAND_BYTES-1:0]   o_op_b,
  output logic [OPCODE_W-1:0]               o_op_code,
  input  logic [BYTE_W*OPERAND_BYTES-1:0]   i_alu_result,
  output logic                              o_busy,
  output logic                              o_frame_err
);
  localparam int W = BYTE_W * OPERAND_BYTES;
  localparam int IW = cnt_w(OPERAND_BYTES);
  localparam logic [IW-1:0] LAST = IW'(OPERAND_BYTES - 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d;
  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [OPCODE_W-1:0] op_code_q, op_code_d;
  logic frame_err_q, frame_err_d;
  logic rx_state, rx_pop, tx_push, last, expired;
  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .enable(rx_state && o_busy),
    .clear(rx_pop),
    .expired(expired)
  );
  always_comb begin
    rx_state = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
    rx_pop = rx_state && !i_rx_empty;
    tx_push = (state_q == TX) && !i_tx_full;
    last = idx_q == LAST;
    state_d = state_q;
    idx_d = idx_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    op_code_d = op_code_q;
    result_d = result_q;
    frame_err_d = 1'b0;
    if (expired) begin
      state_d = RX_A;
      idx_d = '0;
      shadow_a_d = '0;
      shadow_b_d = '0;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        RX_A: if (rx_pop) begin
          shadow_a_d[int'(idx_q)*BYTE_W +: BYTE_W] = i_rx_data;
          idx_d = last ? '0 : idx_q + 1'b1;
          state_d = last ? RX_B : RX_A;
        end
        RX_B: if (rx_pop) begin
          shadow_b_d[int'(idx_q)*BYTE_W +: BYTE_W] = i_rx_data;
          idx_d = last ? '0 : idx_q + 1'b1;
          state_d = last ? RX_OP : RX_B;
        end
        // operands and opcode commit together so the ALU never sees a partial frame
        RX_OP: if (rx_pop) begin
          op_a_d = shadow_a_q;
          op_b_d = shadow_b_q;
          op_code_d = i_rx_data[OPCODE_W-1:0];
          state_d = EXEC;
        end
        EXEC: begin
          result_d = i_alu_result;
          idx_d = '0;
          state_d = TX;
        end
        TX: if (tx_push) begin
          idx_d = last ? '0 : idx_q + 1'b1;
          state_d = last ? RX_A : TX;
        end
        default: begin
          state_d = RX_A;
          idx_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RX_A;
      idx_q <= '0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_code_q <= '0;
      result_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      op_code_q <= op_code_d;
      result_q <= result_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign o_rx_rd = rx_pop;
  assign o_tx_wr = tx_push;
  assign o_tx_data = result_q[int'(idx_q)*BYTE_W +: BYTE_W];
  assign o_op_a = op_a_q;
  assign o_op_b = op_b_q;
  assign o_op_code = op_code_q;
  assign o_busy = !(state_q == RX_A && idx_q == '0);
  assign o_frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb_uart_alu_frame_ctrl: FIFO/ALU environment with a queue-based frame model, vector table and corner sequences
module tb_uart_alu_frame_ctrl;
  localparam int NB = 2;
  localparam int T = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic i_rx_empty = 1'b1;
  logic i_tx_full = 1'b0;
  logic [15:0] i_alu_result = 16'h0000;
  logic o_rx_rd, o_tx_wr, o_busy, o_frame_err;
  logic [7:0] o_tx_data;
  logic [15:0] o_op_a, o_op_b;
  logic [5:0] o_op_code;
  logic z_rx_rd, z_tx_wr, z_busy, z_frame_err;
  logic [7:0] z_tx_data;
  logic [15:0] z_op_a, z_op_b;
  logic [5:0] z_op_code;
  uart_alu_frame_ctrl #(.BYTE_W(8), .OPERAND_BYTES(NB), .OPCODE_W(6), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rx_rd(o_rx_rd),
    .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data), .o_op_a(o_op_a), .o_op_b(o_op_b),
    .o_op_code(o_op_code), .i_alu_result(i_alu_result), .o_busy(o_busy), .o_frame_err(o_frame_err)
  );
  uart_alu_frame_ctrl #(.BYTE_W(8), .OPERAND_BYTES(NB), .OPCODE_W(6), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rx_rd(z_rx_rd),
    .i_tx_full(i_tx_full), .o_tx_wr(z_tx_wr), .o_tx_data(z_tx_data), .o_op_a(z_op_a), .o_op_b(z_op_b),
    .o_op_code(z_op_code), .i_alu_result(i_alu_result), .o_busy(z_busy), .o_frame_err(z_frame_err)
  );
  always #5 clk = ~clk;
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] m_frame[$];
  logic [7:0] m_tx[$];
  logic m_wait, m_exec, m_err;
  int m_idle;
  logic [15:0] m_a, m_b;
  logic [5:0] m_code;
  int n_chk = 0, n_fail = 0, ferr = 0, ferr0 = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [5:0]  code;
    logic [15:0] res;
    bit          stall;
  } vec_t;
  vec_t vt[4];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_frame.delete();
    m_tx.delete();
    m_wait = 1'b0;
    m_exec = 1'b0;
    m_err = 1'b0;
    m_idle = 0;
    m_a = '0;
    m_b = '0;
    m_code = '0;
  endtask
  task automatic push_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    rx_q.push_back(a[7:0]);
    rx_q.push_back(a[15:8]);
    rx_q.push_back(b[7:0]);
    rx_q.push_back(b[15:8]);
    rx_q.push_back(op);
  endtask
  // one clock: present FIFO/ALU inputs, compare against the model, then advance model and FIFOs
  task automatic cyc();
    logic [7:0] b;
    logic pop;
    logic [15:0] res;
    i_rx_empty = rx_q.size() == 0;
    i_rx_data = i_rx_empty ? 8'h00 : rx_q[0];
    i_alu_result = o_op_a + o_op_b;
    #1;
    if (z_frame_err) ferr0++;
    if (!reset) begin
      m_reset();
    end else begin
      pop = !m_wait && !i_rx_empty;
      chk("rx_rd", 64'(o_rx_rd), 64'(pop));
      chk("tx_wr", 64'(o_tx_wr), 64'(m_wait && !m_exec && !i_tx_full));
      chk("busy", 64'(o_busy), 64'(m_wait || m_frame.size() != 0));
      chk("frame_err", 64'(o_frame_err), 64'(m_err));
      chk("ops", 64'({o_op_a, o_op_b, o_op_code}), 64'({m_a, m_b, m_code}));
      if (m_wait && !m_exec && !i_tx_full) chk("tx_data", 64'(o_tx_data), 64'(m_tx[0]));
      if (o_frame_err) ferr++;
      b = i_rx_data;
      if (o_rx_rd) void'(rx_q.pop_front());
      if (o_tx_wr) tx_log.push_back(o_tx_data);
      m_err = 1'b0;
      if (m_exec) m_exec = 1'b0;
      else if (m_wait && !i_tx_full) begin
        void'(m_tx.pop_front());
        m_wait = m_tx.size() != 0;
      end
      if (pop) begin
        m_frame.push_back(b);
        m_idle = 0;
        if (m_frame.size() == 2 * NB + 1) begin
          for (int i = 0; i < NB; i++) begin
            m_a[i*8 +: 8] = m_frame[i];
            m_b[i*8 +: 8] = m_frame[NB+i];
          end
          m_code = b[5:0];
          res = m_a + m_b;
          for (int i = 0; i < NB; i++) m_tx.push_back(res[i*8 +: 8]);
          m_frame.delete();
          m_wait = 1'b1;
          m_exec = 1'b1;
        end
      end else if (m_frame.size() != 0) begin
        m_idle++;
        if (m_idle == T) begin
          m_frame.delete();
          m_idle = 0;
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while ((m_wait || m_frame.size() != 0 || rx_q.size() != 0) && k < lim) begin
      cyc();
      k++;
    end
    chk("idle_reached", 64'(m_wait || m_frame.size() != 0 || rx_q.size() != 0), 64'(0));
  endtask
  function automatic logic [31:0] log_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) if (i < tx_log.size()) w[i*8 +: 8] = tx_log[i];
    return w;
  endfunction
  initial begin
    int k, e0, pause;
    logic [15:0] sa, sb;
    logic [5:0] sc;
    vt[0] = '{16'h1234, 16'h5678, 8'h05, 6'h05, 16'h68AC, 1'b0};
    vt[1] = '{16'h1234, 16'h5678, 8'h05, 6'h05, 16'h68AC, 1'b1};
    vt[2] = '{16'hFFFF, 16'h0001, 8'hC5, 6'h05, 16'h0000, 1'b0};
    vt[3] = '{16'h00FF, 16'h0F0F, 8'h3A, 6'h3A, 16'h100E, 1'b0};
    m_reset();
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_tx_wr", 64'(o_tx_wr), 64'(0));
    chk("rst_tx_data", 64'(o_tx_data), 64'(0));
    chk("rst_ops", 64'({o_op_a, o_op_b, o_op_code}), 64'(0));
    chk("rst_frame_err", 64'(o_frame_err), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tx_log.delete();
      i_tx_full = vt[i].stall;
      push_frame(vt[i].a, vt[i].b, vt[i].op);
      if (vt[i].stall) begin
        k = 0;
        while (!(m_wait && !m_exec) && k < 20) begin
          cyc();
          k++;
        end
        chk("reach_tx", 64'(m_wait && !m_exec), 64'(1));
        repeat (10) cyc();
        chk("stall_hold", 64'(tx_log.size()), 64'(0));
        i_tx_full = 1'b0;
      end
      wait_idle(100);
      chk("vec_tx_count", 64'(tx_log.size()), 64'(NB));
      chk("vec_tx_bytes", 64'(log_word()), 64'(vt[i].res));
      chk("vec_op_a", 64'(o_op_a), 64'(vt[i].a));
      chk("vec_op_b", 64'(o_op_b), 64'(vt[i].b));
      chk("vec_op_code", 64'(o_op_code), 64'(vt[i].code));
    end
    // partial frame dropped after T idle cycles
    e0 = ferr;
    sa = o_op_a;
    sb = o_op_b;
    sc = o_op_code;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    rx_q.push_back(8'h33);
    repeat (3 + T + 3) cyc();
    chk("timeout_pulses", 64'(ferr - e0), 64'(1));
    chk("timeout_idle", 64'(o_busy), 64'(0));
    chk("timeout_ops_kept", 64'({o_op_a, o_op_b, o_op_code}), 64'({sa, sb, sc}));
    tx_log.delete();
    push_frame(16'hA5A5, 16'h0101, 8'h05);
    wait_idle(100);
    chk("after_timeout_tx", 64'(log_word()), 64'(16'hA6A6));
    // byte lands on the would-be expiry cycle
    e0 = ferr;
    tx_log.delete();
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    rx_q.push_back(8'h33);
    k = 0;
    while ((rx_q.size() != 0 || m_idle < T - 1) && k < 60) begin
      cyc();
      k++;
    end
    rx_q.push_back(8'h44);
    cyc();
    rx_q.push_back(8'h05);
    wait_idle(100);
    chk("edge_no_err", 64'(ferr - e0), 64'(0));
    chk("edge_tx", 64'(log_word()), 64'(16'h6644));
    chk("edge_op_a", 64'(o_op_a), 64'(16'h2211));
    // reset after the first result byte
    tx_log.delete();
    push_frame(16'h1111, 16'h2222, 8'h05);
    k = 0;
    while (tx_log.size() < 1 && k < 30) begin
      cyc();
      k++;
    end
    chk("first_push_seen", 64'(tx_log.size()), 64'(1));
    reset = 1'b0;
    i_tx_full = 1'b1;
    cyc();
    reset = 1'b1;
    i_tx_full = 1'b0;
    repeat (5) cyc();
    chk("rst_tx_no_more", 64'(tx_log.size()), 64'(1));
    chk("rst_tx_ops", 64'({o_op_a, o_op_b, o_op_code}), 64'(0));
    chk("rst_tx_busy", 64'(o_busy), 64'(0));
    chk("rst_tx_data", 64'(o_tx_data), 64'(0));
    tx_log.delete();
    push_frame(16'h0F00, 16'h00F0, 8'h05);
    wait_idle(100);
    chk("post_rst_tx", 64'(log_word()), 64'(16'h0FF0));
    // two frames queued back to back
    tx_log.delete();
    push_frame(16'h0001, 16'h0002, 8'h05);
    push_frame(16'hBEEF, 16'h1111, 8'h05);
    wait_idle(200);
    chk("b2b_count", 64'(tx_log.size()), 64'(4));
    chk("b2b_bytes", 64'(log_word()), 64'(32'hD000_0003));
    // random traffic with FIFO backpressure and occasional long gaps
    pause = 0;
    for (int c = 0; c < 4000; c++) begin
      if (pause > 0) pause--;
      else if ($urandom_range(0, 99) < 2) pause = int'($urandom_range(8, 24));
      else if ($urandom_range(0, 2) == 0 && rx_q.size() < 8) rx_q.push_back(8'($urandom));
      i_tx_full = $urandom_range(0, 3) == 0;
      cyc();
    end
    i_tx_full = 1'b0;
    wait_idle(300);
    chk("t0_no_frame_err", 64'(ferr0), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
